// File: rtl/plic_claim_ctrl.sv
// PLIC claim/complete sequencer for hart 0: claims over the PLIC config bus,
// hands the ID to the core, then writes the complete and pulses irq_complete.
module plic_claim_ctrl #(
  parameter logic [31:0] CLAIM_ADDR = 32'h0020_0004,
  parameter int          TIMEOUT    = 16,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             plic_irq_i,
  output logic             plic_complete_o,
  output logic             cfg_en_o,
  output logic             cfg_we_o,
  output logic [31:0]      cfg_addr_o,
  output logic [31:0]      cfg_wdata_o,
  input  logic [31:0]      cfg_rdata_i,
  input  logic             cfg_ready_i,
  output logic             ext_irq_o,
  output logic             claim_valid_o,
  output logic [31:0]      claim_id_o,
  input  logic             claim_ready_i,
  input  logic             done_i,
  input  logic [31:0]      done_id_i,
  output logic             busy_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] spurious_cnt_o,
  output logic [CNT_W-1:0] mismatch_cnt_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CLAIM_REQ, CLAIM_WAIT, DELIVER, SERVICE, COMPLETE_REQ, COMPLETE_WAIT, PULSE
  } state_e;

  state_e            state_q, state_d;
  logic              holdoff_q, holdoff_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [31:0]       id_q, id_d;
  logic              cfg_en_q, cfg_en_d, cfg_we_q, cfg_we_d;
  logic [31:0]       cfg_addr_q, cfg_addr_d, cfg_wdata_q, cfg_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  spur_q, spur_d, mis_q, mis_d;
  logic              valid_q, valid_d, cpl_q, cpl_d, busy_q, busy_d;
  logic              timeout;

  // A ready arriving in the last allowed cycle beats the timeout.
  assign timeout = (timer_q == TW'(TIMEOUT - 1)) && !cfg_ready_i;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    id_d        = id_q;
    cfg_we_d    = cfg_we_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    bus_err_d   = bus_err_q;
    spur_d      = spur_q;
    mis_d       = mis_q;
    case (state_q)
      IDLE: if (plic_irq_i && !holdoff_q) begin
        state_d     = CLAIM_REQ;
        timer_d     = '0;
        cfg_we_d    = 1'b0;
        cfg_addr_d  = CLAIM_ADDR;
        cfg_wdata_d = '0;
      end
      CLAIM_REQ: state_d = CLAIM_WAIT;
      CLAIM_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (cfg_ready_i) begin
          if (cfg_rdata_i == '0) begin
            if (spur_q != '1) spur_d = spur_q + 1'b1;
            state_d = IDLE;
          end else begin
            id_d    = cfg_rdata_i;
            state_d = DELIVER;
          end
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DELIVER: if (claim_ready_i) state_d = SERVICE;
      SERVICE: if (done_i) begin
        if (done_id_i == id_q) begin
          state_d     = COMPLETE_REQ;
          timer_d     = '0;
          cfg_we_d    = 1'b1;
          cfg_addr_d  = CLAIM_ADDR;
          cfg_wdata_d = id_q;
        end else if (mis_q != '1) begin
          mis_d = mis_q + 1'b1;
        end
      end
      COMPLETE_REQ: state_d = COMPLETE_WAIT;
      COMPLETE_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (cfg_ready_i) state_d = PULSE;
        else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = PULSE;
        end
      end
      PULSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    holdoff_d = (state_q != IDLE) && (state_d == IDLE);
    cfg_en_d  = (state_d == CLAIM_REQ) || (state_d == COMPLETE_REQ);
    valid_d   = (state_d == DELIVER);
    cpl_d     = (state_d == PULSE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      holdoff_q   <= 1'b0;
      timer_q     <= '0;
      id_q        <= '0;
      cfg_en_q    <= 1'b0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      spur_q      <= '0;
      mis_q       <= '0;
      valid_q     <= 1'b0;
      cpl_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdoff_q   <= holdoff_d;
      timer_q     <= timer_d;
      id_q        <= id_d;
      cfg_en_q    <= cfg_en_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      bus_err_q   <= bus_err_d;
      spur_q      <= spur_d;
      mis_q       <= mis_d;
      valid_q     <= valid_d;
      cpl_q       <= cpl_d;
      busy_q      <= busy_d;
    end
  end

  // Pass-through while idle; the holdoff cycle masks a stale level from the PLIC.
  assign ext_irq_o       = (state_q == IDLE && !holdoff_q) ? plic_irq_i : (state_q == DELIVER);
  assign plic_complete_o = cpl_q;
  assign cfg_en_o        = cfg_en_q;
  assign cfg_we_o        = cfg_we_q;
  assign cfg_addr_o      = cfg_addr_q;
  assign cfg_wdata_o     = cfg_wdata_q;
  assign claim_valid_o   = valid_q;
  assign claim_id_o      = id_q;
  assign busy_o          = busy_q;
  assign bus_err_o       = bus_err_q;
  assign spurious_cnt_o  = spur_q;
  assign mismatch_cnt_o  = mis_q;
endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Randomized bench for plic_claim_ctrl: transaction-level PLIC/core models
// with an outcome-based reference (counts of accesses, pulses, counters).
module tb_plic_claim_ctrl;
  localparam logic [31:0] CLAIM_ADDR = 32'h0020_0004;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst = 1'b1;
  logic plic_irq_i = 1'b0, cfg_ready_i = 1'b0, claim_ready_i = 1'b0, done_i = 1'b0;
  logic [31:0] cfg_rdata_i = '0, done_id_i = '0;
  logic plic_complete_o, cfg_en_o, cfg_we_o, ext_irq_o, claim_valid_o, busy_o, bus_err_o;
  logic [31:0] cfg_addr_o, cfg_wdata_o, claim_id_o;
  logic [CNT_W-1:0] spurious_cnt_o, mismatch_cnt_o;

  plic_claim_ctrl #(.CLAIM_ADDR(CLAIM_ADDR), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .plic_irq_i(plic_irq_i), .plic_complete_o(plic_complete_o),
    .cfg_en_o(cfg_en_o), .cfg_we_o(cfg_we_o), .cfg_addr_o(cfg_addr_o),
    .cfg_wdata_o(cfg_wdata_o), .cfg_rdata_i(cfg_rdata_i), .cfg_ready_i(cfg_ready_i),
    .ext_irq_o(ext_irq_o), .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o),
    .claim_ready_i(claim_ready_i), .done_i(done_i), .done_id_i(done_id_i),
    .busy_o(busy_o), .bus_err_o(bus_err_o), .spurious_cnt_o(spurious_cnt_o),
    .mismatch_cnt_o(mismatch_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0, cpl_cnt = 0, addr_bad = 0, pulse_viol = 0;
  logic prev_en = 1'b0, prev_cpl = 1'b0;
  int m_spur = 0, m_mis = 0;
  logic m_err = 1'b0;
  logic [31:0] m_id = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Bus/pulse observer: counts accesses and one-cycle-strobe violations.
  always @(negedge clk) begin
    if (cfg_en_o) begin
      if (cfg_we_o) wr_cnt++; else rd_cnt++;
      if (cfg_addr_o !== CLAIM_ADDR) addr_bad++;
      if (prev_en) pulse_viol++;
    end
    if (plic_complete_o) begin
      cpl_cnt++;
      if (prev_cpl) pulse_viol++;
    end
    prev_en  = cfg_en_o;
    prev_cpl = plic_complete_o;
  end

  task automatic wait_en(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (cfg_en_o) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Called at the negedge showing cfg_en_o; answers in wait-cycle d, or never if d >= TIMEOUT.
  task automatic resp(input logic [31:0] v, input int d);
    if (d >= TIMEOUT) repeat (TIMEOUT + 3) @(negedge clk);
    else begin
      repeat (d + 1) @(negedge clk);
      cfg_ready_i = 1'b1; cfg_rdata_i = v;
      @(negedge clk);
      cfg_ready_i = 1'b0; cfg_rdata_i = $urandom;
    end
  endtask

  task automatic deliver(input logic [31:0] id, input int k);
    logic seen, ok;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (claim_valid_o) seen = 1'b1;
      else @(negedge clk);
    end
    chk("claim_valid", seen, 1);
    chk("claim_id", claim_id_o, id);
    chk("ext_irq_deliver", ext_irq_o, 1);
    ok = 1'b1;
    for (int i = 0; i < k; i++) begin
      done_i = (i == 0); done_id_i = id + 7;
      @(negedge clk);
      done_i = 1'b0;
      if (claim_valid_o !== 1'b1 || claim_id_o !== id || cfg_en_o || !ext_irq_o) ok = 1'b0;
    end
    chk("deliver_stable", ok, 1);
    claim_ready_i = 1'b1;
    @(negedge clk);
    claim_ready_i = 1'b0;
    chk("valid_drop", claim_valid_o, 0);
  endtask

  task automatic txn(input logic [31:0] id, input int d1, input int k, input int nmis, input int d2);
    int rd0, wr0, cp0, exp_wr, exp_cp;
    logic seen;
    rd0 = rd_cnt; wr0 = wr_cnt; cp0 = cpl_cnt; exp_wr = 0; exp_cp = 0;
    plic_irq_i = 1'b1;
    wait_en(seen);
    chk("claim_req", seen, 1);
    chk("claim_we", cfg_we_o, 0);
    plic_irq_i = 1'b0;
    resp(id, d1);
    if (d1 >= TIMEOUT) m_err = 1'b1;
    else if (id == 0) m_spur = sat(m_spur);
    else begin
      m_id = id;
      deliver(id, k);
      for (int j = 0; j < nmis; j++) begin
        done_i = 1'b1; done_id_i = id + j + 1;
        @(negedge clk);
        done_i = 1'b0;
        @(negedge clk);
        m_mis = sat(m_mis);
      end
      chk("mis_no_write", wr_cnt - wr0, 0);
      chk("mis_cnt", mismatch_cnt_o, m_mis);
      done_i = 1'b1; done_id_i = id;
      @(negedge clk);
      done_i = 1'b0;
      wait_en(seen);
      chk("cpl_req", seen, 1);
      chk("cpl_we", cfg_we_o, 1);
      chk("cpl_wdata", cfg_wdata_o, id);
      resp($urandom, d2);
      if (d2 >= TIMEOUT) m_err = 1'b1;
      exp_wr = 1; exp_cp = 1;
    end
    repeat (4) @(negedge clk);
    chk("reads", rd_cnt - rd0, 1);
    chk("writes", wr_cnt - wr0, exp_wr);
    chk("cpl_pulses", cpl_cnt - cp0, exp_cp);
    chk("spur_cnt", spurious_cnt_o, m_spur);
    chk("mis_cnt_end", mismatch_cnt_o, m_mis);
    chk("bus_err", bus_err_o, m_err);
    chk("claim_id_hold", claim_id_o, m_id);
    chk("idle", busy_o, 0);
  endtask

  initial begin
    logic seen;
    int cp0, wr0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_id", claim_id_o, 0);
    chk("rst_err", bus_err_o, 0);
    chk("rst_cpl", plic_complete_o, 0);

    txn(5, 1, 0, 0, 1);                 // basic claim/complete
    txn(5, 0, 2, 1, 0);                 // wrong-ID done then correct
    txn(6, TIMEOUT, 0, 0, 0);           // claim read timeout
    txn(7, TIMEOUT - 1, 1, 0, TIMEOUT - 1); // ready on last allowed cycle wins
    txn(8, 2, 10, 0, TIMEOUT);          // long hold, complete timeout still pulses

    // reset while in SERVICE
    cp0 = cpl_cnt; wr0 = wr_cnt;
    plic_irq_i = 1'b1;
    wait_en(seen);
    plic_irq_i = 1'b0;
    resp(9, 2);
    deliver(9, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("srst_valid", claim_valid_o, 0);
    chk("srst_id", claim_id_o, 0);
    chk("srst_busy", busy_o, 0);
    chk("srst_err", bus_err_o, 0);
    chk("srst_spur", spurious_cnt_o, 0);
    chk("srst_mis", mismatch_cnt_o, 0);
    chk("srst_en", cfg_en_o, 0);
    repeat (4) @(negedge clk);
    chk("srst_no_cpl", cpl_cnt - cp0, 0);
    chk("srst_no_wr", wr_cnt - wr0, 0);
    m_spur = 0; m_mis = 0; m_err = 1'b0; m_id = '0;
    txn(10, 3, 1, 0, 2);

    // spurious counter saturation
    for (int i = 0; i < 256; i++) txn(0, $urandom_range(0, 3), 0, 0, 0);
    chk("spur_sat", spurious_cnt_o, CMAX);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] id;
      int d1, d2;
      id = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 1023));
      d1 = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
      d2 = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
      txn(id, d1, $urandom_range(0, 5), $urandom_range(0, 2), d2);
    end

    chk("addr_all", addr_bad, 0);
    chk("strobe_one_cycle", pulse_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
